// File: rtl/fir_sm_fifo.sv
// fir_sm_fifo: first-word-fall-through AXI-stream buffer behind the FIR sm_* port,
// with fill level and frame-completion tracking.
module fir_sm_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16,
  parameter int pPTR_WIDTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   clr,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [pPTR_WIDTH:0]    level,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);
  logic [pDATA_WIDTH:0] mem [pDEPTH];
  logic [pPTR_WIDTH:0]  wr_ptr, rd_ptr;
  logic                 push, pop, last_pop;
  assign level    = wr_ptr - rd_ptr;
  assign s_tready = level != (pPTR_WIDTH+1)'(pDEPTH);
  assign m_tvalid = level != '0;
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign last_pop = pop & m_tlast;
  assign {m_tlast, m_tdata} = mem[rd_ptr[pPTR_WIDTH-1:0]];
  // Storage is never reset; stale contents are hidden by m_tvalid.
  always_ff @(posedge axis_clk)
    if (push) mem[wr_ptr[pPTR_WIDTH-1:0]] <= {s_tlast, s_tdata};
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + (pPTR_WIDTH+1)'(push);
      rd_ptr      <= rd_ptr + (pPTR_WIDTH+1)'(pop);
      frame_done  <= last_pop;
      frame_count <= frame_count + 16'(last_pop);
    end
  end
endmodule

// File: tb/tb_fir_sm_fifo.sv
// tb_fir_sm_fifo: directed sequences and a vector table, with a queue scoreboard
// checking every beat, level, readiness and frame pulse on the falling edge.
module tb_fir_sm_fifo;
  logic        axis_clk = 0, axis_rst, clr, s_tvalid, s_tready, s_tlast;
  logic        m_tvalid, m_tready, m_tlast, frame_done;
  logic [31:0] s_tdata, m_tdata;
  logic [4:0]  level;
  logic [15:0] frame_count;
  int checks = 0, errors = 0, pulses = 0;
  logic [32:0] q [$];
  logic        mv = 0, fd_exp = 0;
  logic [15:0] fc_exp = 0;

  fir_sm_fifo dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .clr(clr),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .level(level), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge axis_clk);
    #1;
  endtask

  // Scoreboard: inputs are stable here, so the handshakes seen now happen at the next edge.
  always @(negedge axis_clk) begin
    logic [32:0] e;
    if (mv) begin
      chk("sb_level", level, q.size());
      chk("sb_s_tready", s_tready, q.size() != 16);
      chk("sb_m_tvalid", m_tvalid, q.size() != 0);
      chk("sb_frame_done", frame_done, fd_exp);
      chk("sb_frame_count", frame_count, fc_exp);
    end
    if (frame_done === 1'b1) pulses++;
    if (axis_rst) begin
      q.delete(); fd_exp = 0; fc_exp = 0; mv = 1;
    end else if (clr) begin
      q.delete(); fd_exp = 0;
    end else if (mv) begin
      fd_exp = 0;
      if (m_tvalid && m_tready && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_beat", {m_tlast, m_tdata}, e);
        if (e[32]) begin fd_exp = 1; fc_exp++; end
      end
      if (s_tvalid && s_tready) q.push_back({s_tlast, s_tdata});
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic sv; logic [31:0] sd; logic sl; logic mr; logic cl;
    logic [4:0] lv; logic srdy; logic mval; logic fd; logic [31:0] md;
  } vec_t;
  vec_t vt [9];

  task automatic do_reset();
    axis_rst = 1; clr = 0; s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 0;
    cyc(); cyc();
    axis_rst = 0;
  endtask

  initial begin
    int sent, c;
    logic acc;
    vt[0] = '{1, 32'hA, 0, 0, 0, 1, 1, 1, 0, 32'hA};
    vt[1] = '{1, 32'hB, 0, 0, 0, 2, 1, 1, 0, 32'hA};
    vt[2] = '{1, 32'hC, 1, 1, 0, 2, 1, 1, 0, 32'hB};
    vt[3] = '{0, 32'h0, 0, 1, 0, 1, 1, 1, 0, 32'hC};
    vt[4] = '{0, 32'h0, 0, 1, 0, 0, 1, 0, 1, 32'h0};
    vt[5] = '{1, 32'hD, 0, 1, 0, 1, 1, 1, 0, 32'hD};
    vt[6] = '{1, 32'hE, 0, 1, 1, 0, 1, 0, 0, 32'h0};
    vt[7] = '{1, 32'hF, 0, 0, 0, 1, 1, 1, 0, 32'hF};
    vt[8] = '{0, 32'h0, 0, 1, 0, 0, 1, 0, 0, 32'h0};

    do_reset();
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_frame_count", frame_count, 0);

    // Fill to full, then offer a 17th beat that must be held off.
    s_tvalid = 1;
    for (int i = 1; i <= 16; i++) begin s_tdata = i; cyc(); end
    chk("fill_level", level, 16);
    chk("fill_s_tready", s_tready, 0);
    s_tdata = 17; cyc();
    chk("full_hold_level", level, 16);
    chk("full_head", m_tdata, 1);
    s_tvalid = 0; m_tready = 1;
    for (int i = 1; i <= 16; i++) begin chk("drain_data", m_tdata, i); cyc(); end
    chk("drain_level", level, 0);
    chk("drain_m_tvalid", m_tvalid, 0);

    // Steady state at level 8 with simultaneous push and pop.
    m_tready = 0; s_tvalid = 1;
    for (int i = 0; i < 8; i++) begin s_tdata = 100 + i; cyc(); end
    m_tready = 1;
    for (int i = 8; i < 108; i++) begin
      s_tdata = 100 + i; cyc();
      chk("steady_level", level, 8);
    end
    s_tvalid = 0;
    for (int i = 0; i < 20 && m_tvalid; i++) cyc();
    chk("steady_empty", m_tvalid, 0);

    // 600-beat frame under random backpressure.
    do_reset();
    pulses = 0; sent = 0;
    s_tvalid = 1; s_tdata = 32'h1234_0000; s_tlast = 0;
    for (c = 0; c < 20000 && !(sent == 600 && q.size() == 0); c++) begin
      m_tready = 1'($urandom_range(0, 1));
      acc = s_tvalid && s_tready;
      cyc();
      if (acc) begin
        sent++;
        if (sent < 600) begin
          s_tdata = 32'h1234_0000 + sent * 7;
          s_tlast = sent == 599;
        end else begin
          s_tvalid = 0; s_tlast = 0;
        end
      end
    end
    chk("frame_complete", c < 20000, 1);
    m_tready = 0;
    cyc(); cyc();
    chk("frame_pulses", pulses, 1);
    chk("frame_count_1", frame_count, 1);

    // Flush with 5 stored beats, then reset mid-frame.
    s_tvalid = 1;
    for (int i = 0; i < 5; i++) begin s_tdata = 500 + i; cyc(); end
    chk("pre_clr_level", level, 5);
    s_tvalid = 0; clr = 1; cyc(); clr = 0;
    chk("clr_level", level, 0);
    chk("clr_m_tvalid", m_tvalid, 0);
    chk("clr_frame_count", frame_count, 1);
    s_tvalid = 1;
    for (int i = 0; i < 3; i++) begin s_tdata = 600 + i; cyc(); end
    s_tvalid = 0;
    axis_rst = 1; cyc(); axis_rst = 0;
    chk("midrst_frame_count", frame_count, 0);
    chk("midrst_s_tready", s_tready, 1);
    chk("midrst_level", level, 0);

    // Cycle-by-cycle vector table from empty.
    for (int i = 0; i < 9; i++) begin
      s_tvalid = vt[i].sv; s_tdata = vt[i].sd; s_tlast = vt[i].sl;
      m_tready = vt[i].mr; clr = vt[i].cl;
      cyc();
      chk($sformatf("vec%0d_level", i), level, vt[i].lv);
      chk($sformatf("vec%0d_s_tready", i), s_tready, vt[i].srdy);
      chk($sformatf("vec%0d_m_tvalid", i), m_tvalid, vt[i].mval);
      chk($sformatf("vec%0d_frame_done", i), frame_done, vt[i].fd);
      if (vt[i].mval) chk($sformatf("vec%0d_m_tdata", i), m_tdata, vt[i].md);
    end
    s_tvalid = 0; clr = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
